// File: rtl/decode_regfile_pipe.sv
// Single-issue decode stage with an NREG x XLEN register file, operand bypass and a
// ready/valid output register. Optional macro ZERO_REG_EN hard-wires register 0 to zero.
module decode_regfile_pipe #(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  parameter int CNTW = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     komut,
  input  logic            we,
  input  logic [4:0]      rd_addr,
  input  logic [XLEN-1:0] rd_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [6:0]      opcode,
  output logic [4:0]      rd,
  output logic [3:0]      aluop,
  output logic [XLEN-1:0] rs1_data,
  output logic [XLEN-1:0] rs2_data,
  output logic [XLEN-1:0] imm,
  output logic            hata,
  output logic [CNTW-1:0] hata_count
);

  typedef enum logic [2:0] {
    FMT_R,
    FMT_I,
    FMT_U,
    FMT_B,
    FMT_ERR
  } fmt_e;

  localparam logic [6:0] OP_R = 7'b0000001;
  localparam logic [6:0] OP_I = 7'b0000011;
  localparam logic [6:0] OP_U = 7'b0000111;
  localparam logic [6:0] OP_B = 7'b0001111;

  // Register file and output stage.
  logic [XLEN-1:0] r_regs [NREG];
  logic            r_out_valid;
  logic [6:0]      r_opcode;
  logic [4:0]      r_rd;
  logic [3:0]      r_aluop;
  logic [XLEN-1:0] r_rs1_data;
  logic [XLEN-1:0] r_rs2_data;
  logic [XLEN-1:0] r_imm;
  logic            r_hata;
  logic [CNTW-1:0] r_hata_count;

  // Decode-side combinational signals.
  logic [4:0]      w_rs1;
  logic [4:0]      w_rs2;
  logic [4:0]      w_rd;
  logic [2:0]      w_funct3;
  fmt_e            w_fmt;
  logic            w_use_rs1;
  logic            w_use_rs2;
  logic            w_use_rd;
  logic            w_hata;
  logic [3:0]      w_aluop;
  logic [XLEN-1:0] w_imm;
  logic [XLEN-1:0] w_rs1_data;
  logic [XLEN-1:0] w_rs2_data;
  logic            w_wr_en;
  logic            w_accept;

  function automatic logic idx_ok(input logic [4:0] idx);
    return ({1'b0, idx} < 6'(NREG));
  endfunction

  assign w_rs1    = komut[19:15];
  assign w_rs2    = komut[24:20];
  assign w_rd     = komut[11:7];
  assign w_funct3 = komut[14:12];

  assign in_ready = !r_out_valid || out_ready;
  assign w_accept = in_valid && in_ready;

`ifdef ZERO_REG_EN
  assign w_wr_en = we && idx_ok(rd_addr) && (rd_addr != 5'd0);
`else
  assign w_wr_en = we && idx_ok(rd_addr);
`endif

  // NOTE: every signal assigned in an always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    w_fmt     = FMT_ERR;
    w_use_rs1 = 1'b0;
    w_use_rs2 = 1'b0;
    w_use_rd  = 1'b0;
    case (komut[6:0])
      OP_R: begin
        w_fmt     = FMT_R;
        w_use_rs1 = 1'b1;
        w_use_rs2 = 1'b1;
        w_use_rd  = 1'b1;
      end
      OP_I: begin
        w_fmt     = FMT_I;
        w_use_rs1 = 1'b1;
        w_use_rd  = 1'b1;
      end
      OP_U: begin
        w_fmt     = FMT_U;
        w_use_rd  = 1'b1;
      end
      OP_B: begin
        w_fmt     = FMT_B;
        w_use_rs1 = 1'b1;
        w_use_rs2 = 1'b1;
      end
      default: w_fmt = FMT_ERR;
    endcase
  end

  assign w_hata = (w_fmt == FMT_ERR)
               || (w_use_rs1 && !idx_ok(w_rs1))
               || (w_use_rs2 && !idx_ok(w_rs2))
               || (w_use_rd  && !idx_ok(w_rd));

  always_comb begin
    w_aluop = 4'b0000;
    w_imm   = '0;
    case (w_fmt)
      FMT_R: w_aluop = {komut[30], w_funct3};
      FMT_I: begin
        w_aluop = {1'b0, w_funct3};
        w_imm   = XLEN'($signed(komut[31:20]));
      end
      FMT_U: w_imm = XLEN'($signed({komut[31:12], 12'b0}));
      FMT_B: begin
        w_aluop = {1'b0, w_funct3};
        w_imm   = XLEN'($signed({komut[31], komut[7], komut[30:25], komut[11:8], 1'b0}));
      end
      default: begin
        w_aluop = 4'b0000;
        w_imm   = '0;
      end
    endcase
  end

  // Operand read: unused or out-of-range indices read zero; a same-cycle write wins.
  function automatic logic [XLEN-1:0] read_operand(input logic [4:0] idx, input logic used);
    logic [XLEN-1:0] val;
    val = '0;
    if (used && idx_ok(idx)) begin
      for (int k = 0; k < NREG; k++) begin
        if (idx == 5'(k)) val = r_regs[k];
      end
      if (w_wr_en && (rd_addr == idx)) val = rd_data;
`ifdef ZERO_REG_EN
      if (idx == 5'd0) val = '0;
`endif
    end
    return val;
  endfunction

  always_comb begin
    w_rs1_data = read_operand(w_rs1, w_use_rs1);
    w_rs2_data = read_operand(w_rs2, w_use_rs2);
  end

  // NOTE: the register file is cleared by reset, so it is built from flops rather than a RAM macro.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < NREG; k++) r_regs[k] <= '0;
    end else begin
      for (int k = 0; k < NREG; k++) begin
        if (w_wr_en && (rd_addr == 5'(k))) r_regs[k] <= rd_data;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_out_valid  <= 1'b0;
      r_opcode     <= '0;
      r_rd         <= '0;
      r_aluop      <= '0;
      r_rs1_data   <= '0;
      r_rs2_data   <= '0;
      r_imm        <= '0;
      r_hata       <= 1'b0;
      r_hata_count <= '0;
    end else begin
      if (w_accept) begin
        r_out_valid <= 1'b1;
        r_opcode    <= komut[6:0];
        r_rd        <= w_rd;
        r_aluop     <= w_aluop;
        r_rs1_data  <= w_rs1_data;
        r_rs2_data  <= w_rs2_data;
        r_imm       <= w_imm;
        r_hata      <= w_hata;
        if (w_hata && (r_hata_count != {CNTW{1'b1}})) begin
          r_hata_count <= r_hata_count + CNTW'(1);
        end
      end else if (out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign out_valid  = r_out_valid;
  assign opcode     = r_opcode;
  assign rd         = r_rd;
  assign aluop      = r_aluop;
  assign rs1_data   = r_rs1_data;
  assign rs2_data   = r_rs2_data;
  assign imm        = r_imm;
  assign hata       = r_hata;
  assign hata_count = r_hata_count;

endmodule

// File: tb/tb_decode_regfile_pipe.sv
// Directed bench for decode_regfile_pipe: decode formats, bypass, stall, saturation, reset.
module tb_decode_regfile_pipe;

  localparam int XLEN = 32;
  localparam int NREG = 32;
  localparam int CNTW = 8;

  logic            clk = 1'b0;
  logic            reset;
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     komut;
  logic            we;
  logic [4:0]      rd_addr;
  logic [XLEN-1:0] rd_data;
  logic            out_valid;
  logic            out_ready;
  logic [6:0]      opcode;
  logic [4:0]      rd;
  logic [3:0]      aluop;
  logic [XLEN-1:0] rs1_data;
  logic [XLEN-1:0] rs2_data;
  logic [XLEN-1:0] imm;
  logic            hata;
  logic [CNTW-1:0] hata_count;

  int checks   = 0;
  int failures = 0;

  decode_regfile_pipe #(.XLEN(XLEN), .NREG(NREG), .CNTW(CNTW)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .komut      (komut),
    .we         (we),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .opcode     (opcode),
    .rd         (rd),
    .aluop      (aluop),
    .rs1_data   (rs1_data),
    .rs2_data   (rs2_data),
    .imm        (imm),
    .hata       (hata),
    .hata_count (hata_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  localparam logic [31:0] K_R   = {7'b0100000, 5'd20, 5'd6, 3'b001, 5'd19, 7'b0000001};
  localparam logic [31:0] K_I   = {12'hFFF, 5'd6, 3'b000, 5'd2, 7'b0000011};
  localparam logic [31:0] K_BYP = {12'h005, 5'd6, 3'b010, 5'd3, 7'b0000011};
  localparam logic [31:0] K_U   = {20'h80001, 5'd4, 7'b0000111};
  localparam logic [31:0] K_B   = {1'b1, 6'b000001, 5'd20, 5'd6, 3'b101, 4'b0010, 1'b0, 7'b0001111};
  localparam logic [31:0] K_ERR = {25'h0, 7'b0010001};
  localparam logic [31:0] K_R0  = {12'h000, 5'd0, 3'b000, 5'd1, 7'b0000011};

  initial begin
    int exp_cnt;
    logic [XLEN-1:0] exp_r0;

    reset     = 1'b0;
    in_valid  = 1'b0;
    komut     = '0;
    we        = 1'b0;
    rd_addr   = '0;
    rd_data   = '0;
    out_ready = 1'b1;

    #2;
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_hata_count", hata_count, 0);
    check("rst_imm", imm, 0);
    #10 reset = 1'b1;
    tick();

    // Load reg6 = 5, reg20 = 7.
    we = 1'b1; rd_addr = 5'd6;  rd_data = 32'd5; tick();
    rd_addr = 5'd20; rd_data = 32'd7; tick();
    we = 1'b0;

    // R-type decode.
    komut = K_R; in_valid = 1'b1; tick();
    in_valid = 1'b0;
    check("r_out_valid", out_valid, 1);
    check("r_opcode", opcode, 7'b0000001);
    check("r_aluop", aluop, 4'b1001);
    check("r_rd", rd, 19);
    check("r_rs1", rs1_data, 5);
    check("r_rs2", rs2_data, 7);
    check("r_imm", imm, 0);
    check("r_hata", hata, 0);
    tick();
    check("drain_out_valid", out_valid, 0);

    // I-type with all-ones immediate.
    komut = K_I; in_valid = 1'b1; tick();
    in_valid = 1'b0;
    check("i_imm", imm, 32'hFFFF_FFFF);
    check("i_aluop", aluop, 0);
    check("i_rs1", rs1_data, 5);
    check("i_rs2", rs2_data, 0);
    check("i_rd", rd, 2);

    // Same-cycle write to rs1 is bypassed.
    komut = K_BYP; in_valid = 1'b1;
    we = 1'b1; rd_addr = 5'd6; rd_data = 32'd9;
    tick();
    check("byp_rs1", rs1_data, 9);
    check("byp_imm", imm, 5);
    check("byp_aluop", aluop, 4'b0010);

    // Stall: hold out_ready low with a pending U-type; a write to reg6 must not disturb held operand.
    out_ready = 1'b0; komut = K_U; in_valid = 1'b1;
    rd_data = 32'd77;
    #1;
    check("stall_in_ready", in_ready, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      we = 1'b0;
      check("stall_valid", out_valid, 1);
      check("stall_rs1", rs1_data, 9);
      check("stall_imm", imm, 5);
      check("stall_in_ready", in_ready, 0);
    end

    // Release: U accepted, then B accepted back-to-back.
    out_ready = 1'b1;
    #1;
    check("release_in_ready", in_ready, 1);
    tick();
    check("u_valid", out_valid, 1);
    check("u_opcode", opcode, 7'b0000111);
    check("u_imm", imm, 32'h8000_1000);
    check("u_aluop", aluop, 0);
    check("u_rs1", rs1_data, 0);
    check("u_rd", rd, 4);
    komut = K_B;
    tick();
    in_valid = 1'b0;
    check("b_valid", out_valid, 1);
    check("b_imm", imm, 32'hFFFF_F024);
    check("b_aluop", aluop, 4'b0101);
    check("b_rs1", rs1_data, 77);
    check("b_rs2", rs2_data, 7);
    check("b_hata", hata, 0);
    check("pre_err_count", hata_count, 0);

    // Unknown opcode stream: count saturates.
    komut = K_ERR; in_valid = 1'b1;
    for (int i = 0; i < 300; i++) begin
      tick();
      exp_cnt = (i + 1 > 255) ? 255 : i + 1;
      check("err_hata", hata, 1);
      check("err_count", hata_count, exp_cnt);
    end
    check("err_aluop", aluop, 0);
    check("err_imm", imm, 0);
    in_valid = 1'b0;
    tick();
    check("err_drain", out_valid, 0);

    // Register 0 behaviour.
    we = 1'b1; rd_addr = 5'd0; rd_data = 32'd3; tick();
    we = 1'b0;
    komut = K_R0; in_valid = 1'b1; tick();
    in_valid = 1'b0;
`ifdef ZERO_REG_EN
    exp_r0 = 32'd0;
`else
    exp_r0 = 32'd3;
`endif
    check("reg0_read", rs1_data, exp_r0);
    check("reg0_count_held", hata_count, 255);

    // Reset mid-handshake discards the held result.
    komut = K_R; in_valid = 1'b1; out_ready = 1'b0; tick();
    in_valid = 1'b0;
    check("pre_rst_valid", out_valid, 1);
    #2 reset = 1'b0;
    #1;
    check("async_rst_valid", out_valid, 0);
    check("async_rst_rs1", rs1_data, 0);
    check("async_rst_count", hata_count, 0);
    check("async_rst_in_ready", in_ready, 1);
    #2 reset = 1'b1;
    out_ready = 1'b1;
    tick();
    check("no_replay", out_valid, 0);
    komut = K_R; in_valid = 1'b1; tick();
    in_valid = 1'b0;
    check("regs_cleared_rs1", rs1_data, 0);
    check("regs_cleared_rs2", rs2_data, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
